uesprit_acc_scheduler: RTL and testbench

Integration scheduler for the vector U-ESPRIT correlation datapath. It aligns the two-channel spectral stream to the FFT frame sync and gates the stream into the correlator. It drives the correlator's `new_acc` so that each integration spans exactly `acc_len` spectra, and it tags the correlator's output words with channel index, last-channel flag and integration number for downstream readout.

---
 rtl/uesprit_acc_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_uesprit_acc_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uesprit_acc_scheduler.sv
// uesprit_acc_scheduler
//
// Integration scheduler for the vector U-ESPRIT correlation datapath. Aligns the two-channel
// spectral stream to the FFT frame sync, gates it into the correlator, drives the correlator
// new_acc so each integration spans exactly acc_len spectra, and tags correlator output words
// with channel index, last-channel flag and integration number.
//
// Optional feature macro: UESPRIT_SYNC_CHECK_EN
//   defined   : a sync arriving mid-spectrum sets sticky sync_err_o and re-aligns on that sample.
//   undefined : sync_in_i is ignored outside WAIT_SYNC and sync_err_o is tied to 0.
//
// Ports
//   clk_i, rst_i (synchronous, active-high)
//   arm_i              level, permits starting integrations
//   acc_len_i          spectra per integration (0 treated as 1), sampled at boundaries
//   sync_in_i          pulse concurrent with channel 0 of a spectrum
//   din{1,2}_{re,im}_i antenna samples, qualified by din_valid_i
//   corr_din*_o        registered samples / qualifier to the correlator (1-cycle latency)
//   corr_new_acc_o     correlator new_acc, high on every sample of spectrum 0
//   corr_dout_valid_i  correlator dout_valid
//   dout_chan_o, dout_last_o, dout_frame_o  combinational tags for the current output word
//   busy_o             high while integrating
//   sync_err_o         sticky misalignment flag

module uesprit_acc_scheduler #(
    parameter int unsigned DIN_WIDTH     = 18,
    parameter int unsigned VECTOR_LEN    = 512,
    parameter int unsigned ACC_LEN_WIDTH = 16,
    parameter int unsigned FRAME_WIDTH   = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           arm_i,
    input  logic [ACC_LEN_WIDTH-1:0]       acc_len_i,
    input  logic                           sync_in_i,
    input  logic signed [DIN_WIDTH-1:0]    din1_re_i,
    input  logic signed [DIN_WIDTH-1:0]    din1_im_i,
    input  logic signed [DIN_WIDTH-1:0]    din2_re_i,
    input  logic signed [DIN_WIDTH-1:0]    din2_im_i,
    input  logic                           din_valid_i,
    output logic signed [DIN_WIDTH-1:0]    corr_din1_re_o,
    output logic signed [DIN_WIDTH-1:0]    corr_din1_im_o,
    output logic signed [DIN_WIDTH-1:0]    corr_din2_re_o,
    output logic signed [DIN_WIDTH-1:0]    corr_din2_im_o,
    output logic                           corr_din_valid_o,
    output logic                           corr_new_acc_o,
    input  logic                           corr_dout_valid_i,
    output logic [$clog2(VECTOR_LEN)-1:0]  dout_chan_o,
    output logic                           dout_last_o,
    output logic [FRAME_WIDTH-1:0]         dout_frame_o,
    output logic                           busy_o,
    output logic                           sync_err_o
);

    localparam int unsigned ChanWidth = $clog2(VECTOR_LEN);
    localparam logic [ChanWidth-1:0] ChanLast = ChanWidth'(VECTOR_LEN - 1);
    localparam logic [ChanWidth-1:0] ChanOne  = ChanWidth'(1);
    localparam logic [ACC_LEN_WIDTH-1:0] AccOne = ACC_LEN_WIDTH'(1);
    localparam logic [FRAME_WIDTH-1:0] FrameOne = FRAME_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StWaitSync, StAccum} state_e;

    state_e                   state_q, state_d;
    logic [ChanWidth-1:0]     chan_q, chan_d;
    logic [ACC_LEN_WIDTH-1:0] spec_q, spec_d;
    logic [ACC_LEN_WIDTH-1:0] acc_len_q, acc_len_d;
    logic [ChanWidth-1:0]     ochan_q, ochan_d;
    logic [FRAME_WIDTH-1:0]   frame_q, frame_d;
    logic                     valid_q, new_acc_q;

    logic                     fwd, first, start, realign;
    logic [ACC_LEN_WIDTH-1:0] acc_len_eff;

    assign acc_len_eff = (acc_len_i == '0) ? AccOne : acc_len_i;

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        spec_d    = spec_q;
        acc_len_d = acc_len_q;
        ochan_d   = ochan_q;
        frame_d   = frame_q;
        fwd       = 1'b0;
        first     = 1'b0;
        start     = 1'b0;
        realign   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arm_i) state_d = StWaitSync;
            end
            StWaitSync: begin
                if (sync_in_i && din_valid_i) start = 1'b1;
            end
            StAccum: begin
                if (din_valid_i) begin
`ifdef UESPRIT_SYNC_CHECK_EN
                    realign = sync_in_i && (chan_q != '0);
`endif
                    if (realign) begin
                        start = 1'b1;
                    end else begin
                        fwd    = 1'b1;
                        first  = (spec_q == '0);
                        chan_d = chan_q + ChanOne;  // power-of-two length wraps naturally
                        if (chan_q == ChanLast) begin
                            if (spec_q == acc_len_q - AccOne) begin
                                if (arm_i) begin
                                    acc_len_d = acc_len_eff;
                                    spec_d    = '0;
                                end else begin
                                    state_d = StIdle;
                                end
                            end else begin
                                spec_d = spec_q + AccOne;
                            end
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // The sync sample itself is channel 0 of spectrum 0, so the next one is channel 1.
        if (start) begin
            fwd       = 1'b1;
            first     = 1'b1;
            acc_len_d = acc_len_eff;
            spec_d    = '0;
            chan_d    = ChanOne;
            state_d   = StAccum;
        end

        if (realign) begin
            ochan_d = '0;
            frame_d = '0;
        end else if (corr_dout_valid_i) begin
            ochan_d = ochan_q + ChanOne;
            if (ochan_q == ChanLast) frame_d = frame_q + FrameOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            chan_q         <= '0;
            spec_q         <= '0;
            acc_len_q      <= '0;
            ochan_q        <= '0;
            frame_q        <= '0;
            valid_q        <= 1'b0;
            new_acc_q      <= 1'b0;
            corr_din1_re_o <= '0;
            corr_din1_im_o <= '0;
            corr_din2_re_o <= '0;
            corr_din2_im_o <= '0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            spec_q    <= spec_d;
            acc_len_q <= acc_len_d;
            ochan_q   <= ochan_d;
            frame_q   <= frame_d;
            valid_q   <= fwd;
            new_acc_q <= fwd && first;
            if (fwd) begin
                corr_din1_re_o <= din1_re_i;
                corr_din1_im_o <= din1_im_i;
                corr_din2_re_o <= din2_re_i;
                corr_din2_im_o <= din2_im_i;
            end
        end
    end

`ifdef UESPRIT_SYNC_CHECK_EN
    logic sync_err_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_err_q <= 1'b0;
        else if (realign) sync_err_q <= 1'b1;
    end
    assign sync_err_o = sync_err_q;
`else
    assign sync_err_o = 1'b0;
`endif

    assign corr_din_valid_o = valid_q;
    assign corr_new_acc_o   = new_acc_q;
    assign busy_o           = (state_q == StAccum);
    assign dout_chan_o      = ochan_q;
    assign dout_last_o      = (ochan_q == ChanLast);
    assign dout_frame_o     = frame_q;

endmodule

// File: tb/tb_uesprit_acc_scheduler.sv
module tb_uesprit_acc_scheduler;

    localparam int unsigned DW  = 8;
    localparam int unsigned VL  = 8;
    localparam int unsigned ALW = 4;
    localparam int unsigned FW  = 4;
    localparam int unsigned CW  = $clog2(VL);
    localparam int unsigned FrameMod = 1 << FW;
    localparam int unsigned LogN = 256;
`ifdef UESPRIT_SYNC_CHECK_EN
    localparam bit SyncCheck = 1'b1;
`else
    localparam bit SyncCheck = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic arm = 1'b0;
    logic [ALW-1:0] acc_len = '0;
    logic sync_in = 1'b0;
    logic signed [DW-1:0] d1r = '0, d1i = '0, d2r = '0, d2i = '0;
    logic din_valid = 1'b0;
    logic signed [DW-1:0] c1r, c1i, c2r, c2i;
    logic c_valid, c_new;
    logic dout_valid = 1'b0;
    logic [CW-1:0] dout_chan;
    logic dout_last;
    logic [FW-1:0] dout_frame;
    logic busy, sync_err;

    uesprit_acc_scheduler #(
        .DIN_WIDTH    (DW),
        .VECTOR_LEN   (VL),
        .ACC_LEN_WIDTH(ALW),
        .FRAME_WIDTH  (FW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .arm_i            (arm),
        .acc_len_i        (acc_len),
        .sync_in_i        (sync_in),
        .din1_re_i        (d1r),
        .din1_im_i        (d1i),
        .din2_re_i        (d2r),
        .din2_im_i        (d2i),
        .din_valid_i      (din_valid),
        .corr_din1_re_o   (c1r),
        .corr_din1_im_o   (c1i),
        .corr_din2_re_o   (c2r),
        .corr_din2_im_o   (c2i),
        .corr_din_valid_o (c_valid),
        .corr_new_acc_o   (c_new),
        .corr_dout_valid_i(dout_valid),
        .dout_chan_o      (dout_chan),
        .dout_last_o      (dout_last),
        .dout_frame_o     (dout_frame),
        .busy_o           (busy),
        .sync_err_o       (sync_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int sidx = 0;
    bit log_new [LogN];
    int n_log = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks the sample position within the current integration.
    int unsigned m_mode = 0;  // 0 idle, 1 waiting for sync, 2 integrating
    int unsigned m_pos = 0, m_len = 1, m_dchan = 0, m_dframe = 0;
    bit m_err = 0, m_valid = 0, m_new = 0;
    logic signed [DW-1:0] m_1r = '0, m_1i = '0, m_2r = '0, m_2i = '0;

    always @(posedge clk) begin
        bit realign;
        int unsigned eff;
        realign = 1'b0;
        eff = (acc_len == 0) ? 1 : int'(acc_len);
        if (rst) begin
            m_mode = 0; m_pos = 0; m_len = 1; m_err = 0; m_dchan = 0; m_dframe = 0;
            m_valid = 0; m_new = 0; m_1r = '0; m_1i = '0; m_2r = '0; m_2i = '0;
        end else begin
            m_valid = 0;
            m_new = 0;
            if (m_mode == 0) begin
                if (arm) m_mode = 1;
            end else if (m_mode == 1) begin
                if (sync_in && din_valid) begin
                    m_len = eff; m_pos = 1; m_mode = 2;
                    m_valid = 1; m_new = 1;
                end
            end else if (din_valid) begin
                realign = SyncCheck && sync_in && (m_pos % VL != 0);
                m_valid = 1;
                if (realign) begin
                    m_err = 1; m_len = eff; m_pos = 1; m_new = 1;
                end else begin
                    m_new = (m_pos < VL);
                    if (m_pos == m_len * VL - 1) begin
                        if (arm) begin m_len = eff; m_pos = 0; end
                        else m_mode = 0;
                    end else m_pos++;
                end
            end
            if (m_valid) begin m_1r = d1r; m_1i = d1i; m_2r = d2r; m_2i = d2i; end
            if (realign) begin
                m_dchan = 0; m_dframe = 0;
            end else if (dout_valid) begin
                if (m_dchan == VL - 1) begin
                    m_dchan = 0; m_dframe = (m_dframe + 1) % FrameMod;
                end else m_dchan++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("corr_din_valid", c_valid, m_valid);
            chk("corr_new_acc", c_new, m_new);
            chk("busy", busy, m_mode == 2);
            chk("sync_err", sync_err, m_err);
            chk("dout_chan", dout_chan, m_dchan);
            chk("dout_last", dout_last, m_dchan == VL - 1);
            chk("dout_frame", dout_frame, m_dframe);
            if (m_valid) begin
                chk("corr_din1_re", c1r, m_1r);
                chk("corr_din1_im", c1i, m_1i);
                chk("corr_din2_re", c2r, m_2r);
                chk("corr_din2_im", c2i, m_2i);
            end
            if (c_valid === 1'b1 && n_log < LogN) begin
                log_new[n_log] = c_new;
                n_log++;
            end
        end
    end

    task automatic cyc(input bit v, input bit s, input bit dov);
        din_valid = v;
        sync_in = s;
        dout_valid = dov;
        d1r = DW'($urandom); d1i = DW'($urandom); d2r = DW'($urandom); d2i = DW'($urandom);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        arm = 1'b0;
        rst = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst = 1'b0;
        n_log = 0;
        sidx = 0;
    endtask

    task automatic start(input int unsigned acc);
        acc_len = ALW'(acc);
        arm = 1'b1;
        cyc(0, 0, 0);
    endtask

    // Aligned stream sample: sync on channel 0 of every spectrum.
    task automatic samp(input bit dov);
        cyc(1, (sidx % VL) == 0, dov);
        sidx++;
    endtask

    initial begin
        int ones;
        cyc(0, 0, 0);
        chk_en = 1'b1;
        do_reset();
        chk("reset_valid", c_valid, 0);
        chk("reset_new_acc", c_new, 0);
        chk("reset_busy", busy, 0);
        chk("reset_data", c1r, 0);
        chk("reset_dout_chan", dout_chan, 0);
        chk("reset_dout_frame", dout_frame, 0);

        // 1: acc_len=3, continuous stream; one-cycle latency on the first sample.
        start(3);
        chk("pre_valid", c_valid, 0);
        samp(0);
        chk("lat_valid", c_valid, 1);
        chk("lat_data", c1r, d1r);
        for (int i = 1; i < 32; i++) samp(0);
        cyc(0, 0, 0);
        ones = 0;
        for (int i = 0; i < 24; i++) ones += int'(log_new[i]);
        chk("t1_ones_0_23", ones, 8);
        chk("t1_new_7", log_new[7], 1);
        chk("t1_new_8", log_new[8], 0);
        chk("t1_new_23", log_new[23], 0);
        chk("t1_new_24", log_new[24], 1);

        // 2: valid toggling 1010...
        do_reset();
        start(3);
        for (int i = 0; i < 60; i++) begin
            if (i % 2 == 0) samp(0);
            else cyc(0, 0, 0);
        end
        cyc(0, 0, 0);
        ones = 0;
        for (int i = 0; i < 24; i++) ones += int'(log_new[i]);
        chk("t2_ones_0_23", ones, 8);
        chk("t2_new_24", log_new[24], 1);

        // 3: acc_len 3 -> 2 mid-integration, later 0 (treated as 1).
        do_reset();
        start(3);
        for (int i = 0; i < 80; i++) begin
            if (i == 8) acc_len = ALW'(2);
            if (i == 41) acc_len = ALW'(0);
            samp(0);
        end
        cyc(0, 0, 0);
        chk("t3_new_16", log_new[16], 0);
        chk("t3_new_24", log_new[24], 1);
        chk("t3_new_32", log_new[32], 0);
        chk("t3_new_40", log_new[40], 1);
        chk("t3_new_48", log_new[48], 0);
        chk("t3_new_56", log_new[56], 1);
        chk("t3_new_64", log_new[64], 1);
        chk("t3_new_72", log_new[72], 1);

        // 4: arm dropped at spectrum 1 of 3.
        do_reset();
        start(3);
        for (int i = 0; i < 40; i++) begin
            if (i == 8) arm = 1'b0;
            samp(0);
        end
        cyc(0, 0, 0);
        chk("t4_forwarded", n_log, 24);
        chk("t4_busy", busy, 0);

        // 5: sync injected at chan_cnt=5.
        do_reset();
        start(3);
        for (int i = 0; i < 13; i++) samp(i < 3);
        cyc(1, 1, 0);
        if (SyncCheck) begin
            chk("t5_sync_err", sync_err, 1);
            chk("t5_new_acc", c_new, 1);
            chk("t5_dout_chan", dout_chan, 0);
        end else begin
            chk("t5_sync_err", sync_err, 0);
            chk("t5_new_acc", c_new, 0);
            chk("t5_dout_chan", dout_chan, 3);
        end
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("t5_sync_err_sticky", sync_err, SyncCheck);

        // 6: output tagging.
        do_reset();
        for (int p = 1; p <= 16; p++) begin
            chk("t6_last", dout_last, (p == 8) || (p == 16));
            chk("t6_frame", dout_frame, (p <= 8) ? 0 : 1);
            cyc(0, 0, 1);
        end
        chk("t6_frame_2", dout_frame, 2);
        chk("t6_chan_0", dout_chan, 0);
        for (int p = 0; p < 112; p++) cyc(0, 0, 1);
        chk("t6_frame_wrap", dout_frame, 0);
        for (int p = 0; p < 3; p++) cyc(0, 0, 1);
        chk("t6_chan_3", dout_chan, 3);
        rst = 1'b1;
        cyc(0, 0, 1);
        rst = 1'b0;
        chk("t6_rst_chan", dout_chan, 0);
        chk("t6_rst_frame", dout_frame, 0);

        // Randomized traffic.
        do_reset();
        acc_len = ALW'($urandom_range(3));
        for (int i = 0; i < 3000; i++) begin
            bit v, s;
            rst = ($urandom_range(299) == 0);
            if (rst) sidx = 0;
            arm = ($urandom_range(9) != 0);
            if ($urandom_range(19) == 0) acc_len = ALW'($urandom_range(3));
            v = ($urandom_range(3) != 0);
            if (v && (sidx % VL) == 0) s = ($urandom_range(9) != 0);
            else s = ($urandom_range(32) == 0);
            cyc(v, s, $urandom_range(1) == 1);
            if (v) sidx++;
        end
        rst = 1'b0;
        cyc(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
